// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multicycle RV32I main controller and ALU_decoder:
// opcodes, FSM state codes, ALUOp and datapath mux selects.
package multicycle_main_fsm_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_supported_op(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: is_supported_op = 1'b1;
            default:                                  is_supported_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath (slave).
interface multicycle_main_fsm_if;
    import multicycle_main_fsm_pkg::*;

    logic [6:0] op;
    logic       MemReady;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       Illegal;
    logic       InstrDone;

    modport master (
        input  op, MemReady,
        output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, InstrDone
    );

    modport slave (
        output op, MemReady,
        input  PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, InstrDone
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I datapath: Moore decode of the state,
// with memory-side strobes qualified by MemReady.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_main_fsm_if.master  bus
);

    state_e     state_q;
    state_e     state_d;
    logic       ready_s;

    logic       pc_update_s;
    logic       branch_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       adr_src_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       illegal_s;
    logic       instr_done_s;

    assign ready_s = WAIT_MEM ? bus.MemReady : 1'b1;

    // State register with synchronous reset into FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = ready_s ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = ready_s ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode; unreachable encodings leave every output at 0.
    always_comb begin
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RD2;
        alu_op_s     = ALUOP_ADD;
        illegal_s    = 1'b0;
        instr_done_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s   = ready_s;
                pc_update_s  = ready_s;
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
            end
            S_DECODE: begin
                // Branch target is precomputed here from OldPC + imm.
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                if (is_supported_op(bus.op)) begin
                    illegal_s    = 1'b0;
                    instr_done_s = 1'b0;
                end else begin
                    illegal_s    = 1'b1;
                    instr_done_s = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = ready_s;
                instr_done_s = ready_s;
            end
            S_EXECR: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_RD2;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_JAL: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                pc_update_s = 1'b1;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s  = SRCA_RD1;
                alu_src_b_s  = SRCB_RD2;
                alu_op_s     = ALUOP_SUB;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            default: begin
                pc_update_s = 1'b0;
            end
        endcase
    end

    assign bus.PCUpdate  = pc_update_s;
    assign bus.Branch    = branch_s;
    assign bus.RegWrite  = reg_write_s;
    assign bus.MemWrite  = mem_write_s;
    assign bus.IRWrite   = ir_write_s;
    assign bus.AdrSrc    = adr_src_s;
    assign bus.ResultSrc = result_src_s;
    assign bus.ALUSrcA   = alu_src_a_s;
    assign bus.ALUSrcB   = alu_src_b_s;
    assign bus.ALUOp     = alu_op_s;
    assign bus.Illegal   = illegal_s;
    assign bus.InstrDone = instr_done_s;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: one instance waits on MemReady, a second
// one is built with WAIT_MEM=0 and runs with MemReady held low.
module tb_multicycle_main_fsm;

    // Packed output vector: PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,
    // ResultSrc[1:0],ALUSrcA[1:0],ALUSrcB[1:0],ALUOp[1:0],Illegal,InstrDone
    localparam logic [15:0] E_FETCH    = 16'b1_0_0_0_1_0_10_00_10_00_0_0;
    localparam logic [15:0] E_FETCHW   = 16'b0_0_0_0_0_0_10_00_10_00_0_0;
    localparam logic [15:0] E_DECODE   = 16'b0_0_0_0_0_0_00_01_01_00_0_0;
    localparam logic [15:0] E_DECILL   = 16'b0_0_0_0_0_0_00_01_01_00_1_1;
    localparam logic [15:0] E_MEMADR   = 16'b0_0_0_0_0_0_00_10_01_00_0_0;
    localparam logic [15:0] E_MEMREAD  = 16'b0_0_0_0_0_1_00_00_00_00_0_0;
    localparam logic [15:0] E_MEMWB    = 16'b0_0_1_0_0_0_01_00_00_00_0_1;
    localparam logic [15:0] E_MEMWR_W  = 16'b0_0_0_0_0_1_00_00_00_00_0_0;
    localparam logic [15:0] E_MEMWR    = 16'b0_0_0_1_0_1_00_00_00_00_0_1;
    localparam logic [15:0] E_EXECR    = 16'b0_0_0_0_0_0_00_10_00_10_0_0;
    localparam logic [15:0] E_EXECI    = 16'b0_0_0_0_0_0_00_10_01_10_0_0;
    localparam logic [15:0] E_JAL      = 16'b1_0_0_0_0_0_00_01_10_00_0_0;
    localparam logic [15:0] E_ALUWB    = 16'b0_0_1_0_0_0_00_00_00_00_0_1;
    localparam logic [15:0] E_BEQ      = 16'b0_1_0_0_0_0_00_10_00_01_0_1;

    logic clk;
    logic reset;
    logic reset2;
    int   checks;
    int   failures;

    multicycle_main_fsm_if bus1 ();
    multicycle_main_fsm_if bus2 ();

    multicycle_main_fsm #(.WAIT_MEM(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    multicycle_main_fsm #(.WAIT_MEM(1'b0)) dut_nowait (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.master)
    );

    logic [15:0] outs1;
    logic [15:0] outs2;

    assign outs1 = {bus1.PCUpdate, bus1.Branch, bus1.RegWrite, bus1.MemWrite, bus1.IRWrite,
                    bus1.AdrSrc, bus1.ResultSrc, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp,
                    bus1.Illegal, bus1.InstrDone};
    assign outs2 = {bus2.PCUpdate, bus2.Branch, bus2.RegWrite, bus2.MemWrite, bus2.IRWrite,
                    bus2.AdrSrc, bus2.ResultSrc, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUOp,
                    bus2.Illegal, bus2.InstrDone};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge before the call; compare, then advance one cycle.
    task automatic step1(input string tag, input logic [15:0] exp);
        #1;
        chk(tag, outs1, exp);
        @(negedge clk);
    endtask

    task automatic step2(input string tag, input logic [15:0] exp);
        #1;
        chk(tag, outs2, exp);
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        reset2        = 1'b1;
        bus1.op       = 7'b0000000;
        bus1.MemReady = 1'b1;
        bus2.op       = 7'b0000011;
        bus2.MemReady = 1'b0;
        repeat (2) @(negedge clk);

        // Reset lands in FETCH
        step1("reset_fetch", E_FETCH);
        reset = 1'b0;

        // lw, MemReady held 1: 5 cycles
        bus1.op = 7'b0000011;
        step1("lw_fetch",   E_FETCH);
        step1("lw_decode",  E_DECODE);
        step1("lw_memadr",  E_MEMADR);
        step1("lw_memread", E_MEMREAD);
        step1("lw_memwb",   E_MEMWB);

        // Fetch stall, then sw with three wait cycles in MEMWRITE
        bus1.op = 7'b0100011;
        bus1.MemReady = 1'b0;
        step1("fetch_wait0", E_FETCHW);
        step1("fetch_wait1", E_FETCHW);
        bus1.MemReady = 1'b1;
        step1("sw_fetch",   E_FETCH);
        step1("sw_decode",  E_DECODE);
        step1("sw_memadr",  E_MEMADR);
        bus1.MemReady = 1'b0;
        step1("sw_wait0",   E_MEMWR_W);
        step1("sw_wait1",   E_MEMWR_W);
        step1("sw_wait2",   E_MEMWR_W);
        bus1.MemReady = 1'b1;
        step1("sw_write",   E_MEMWR);

        // R-type then I-type then beq
        bus1.op = 7'b0110011;
        step1("r_fetch",    E_FETCH);
        step1("r_decode",   E_DECODE);
        step1("r_execr",    E_EXECR);
        step1("r_aluwb",    E_ALUWB);
        bus1.op = 7'b0010011;
        step1("i_fetch",    E_FETCH);
        step1("i_decode",   E_DECODE);
        step1("i_execi",    E_EXECI);
        step1("i_aluwb",    E_ALUWB);
        bus1.op = 7'b1100011;
        step1("beq_fetch",  E_FETCH);
        step1("beq_decode", E_DECODE);
        step1("beq_beq",    E_BEQ);

        // jal then an illegal opcode
        bus1.op = 7'b1101111;
        step1("jal_fetch",  E_FETCH);
        step1("jal_decode", E_DECODE);
        step1("jal_jal",    E_JAL);
        step1("jal_aluwb",  E_ALUWB);
        bus1.op = 7'b0000000;
        step1("ill_fetch",  E_FETCH);
        step1("ill_decode", E_DECILL);
        bus1.op = 7'b1111111;
        step1("ill_back",   E_FETCH);
        step1("ill2_decode", E_DECILL);

        // Reset while stalled in MEMREAD abandons the load
        bus1.op = 7'b0000011;
        step1("rst_fetch",  E_FETCH);
        step1("rst_decode", E_DECODE);
        step1("rst_memadr", E_MEMADR);
        bus1.MemReady = 1'b0;
        step1("rst_memread0", E_MEMREAD);
        reset = 1'b1;
        step1("rst_memread1", E_MEMREAD);
        reset = 1'b0;
        bus1.MemReady = 1'b1;
        step1("rst_to_fetch", E_FETCH);
        bus1.op = 7'b0110011;
        step1("post_rst_decode", E_DECODE);

        // WAIT_MEM=0 instance: MemReady=0 is ignored
        reset2 = 1'b0;
        step2("nw_lw_fetch",   E_FETCH);
        step2("nw_lw_decode",  E_DECODE);
        step2("nw_lw_memadr",  E_MEMADR);
        step2("nw_lw_memread", E_MEMREAD);
        step2("nw_lw_memwb",   E_MEMWB);
        bus2.op = 7'b0100011;
        step2("nw_sw_fetch",   E_FETCH);
        step2("nw_sw_decode",  E_DECODE);
        step2("nw_sw_memadr",  E_MEMADR);
        step2("nw_sw_write",   E_MEMWR);
        step2("nw_sw_back",    E_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
